// File: rtl/race_controller.sv
// Race sequencer: walks MENU -> GAME -> END, arbitrates the leader, latches
// the winner set and counts race time in prescaled ticks.
module race_controller #(
    parameter int MAX_POS        = 16,
    parameter int TICK_CLK_COUNT = 50000000,
    parameter int TIME_W         = 8,
    localparam int PW            = $clog2(MAX_POS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_all,
    input  logic              is_in_menu,
    input  logic              red_ready_to_play,
    input  logic              blue_ready_to_play,
    input  logic              green_ready_to_play,
    input  logic              yellow_ready_to_play,
    input  logic [PW-1:0]     red_cur_pos,
    input  logic [PW-1:0]     blue_cur_pos,
    input  logic [PW-1:0]     green_cur_pos,
    input  logic [PW-1:0]     yellow_cur_pos,
    output logic [1:0]        current_screen,
    output logic [3:0]        winner_mask,
    output logic              leader_valid,
    output logic [1:0]        leader_id,
    output logic [TIME_W-1:0] race_ticks
);

    typedef enum logic [1:0] {
        S_MENU = 2'b00,
        S_GAME = 2'b01,
        S_END  = 2'b10
    } state_e;

    localparam int              PSW        = (TICK_CLK_COUNT > 1) ? $clog2(TICK_CLK_COUNT) : 1;
    localparam logic [PSW-1:0]  PRESC_LAST = PSW'(TICK_CLK_COUNT - 1);
    localparam logic [PW-1:0]   FINISH_POS = PW'(MAX_POS - 1);
    localparam logic [TIME_W-1:0] TICKS_MAX = '1;

    state_e              state_q, state_d;
    logic                in_menu_q, in_menu_d;
    logic                menu_fall_q, menu_fall_d;
    logic [3:0]          winner_q, winner_d;
    logic                leader_valid_q, leader_valid_d;
    logic [1:0]          leader_id_q, leader_id_d;
    logic [TIME_W-1:0]   ticks_q, ticks_d;
    logic [PSW-1:0]      presc_q, presc_d;

    logic [3:0]          ready;
    logic [PW-1:0]       pos [4];
    logic [3:0]          finish;
    logic                lead_found;
    logic [1:0]          lead_id;
    logic [PW-1:0]       lead_pos;

    assign ready  = {yellow_ready_to_play, green_ready_to_play, blue_ready_to_play, red_ready_to_play};
    assign pos[0] = red_cur_pos;
    assign pos[1] = blue_cur_pos;
    assign pos[2] = green_cur_pos;
    assign pos[3] = yellow_cur_pos;

    // Strict '>' keeps the lowest index on ties, giving red > blue > green > yellow.
    always_comb begin
        finish     = '0;
        lead_found = 1'b0;
        lead_id    = '0;
        lead_pos   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            finish[i] = ready[i] && (pos[i] == FINISH_POS);
            if (ready[i] && (!lead_found || pos[i] > lead_pos)) begin
                lead_found = 1'b1;
                lead_id    = 2'(i);
                lead_pos   = pos[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        ticks_d     = ticks_q;
        presc_d     = presc_q;
        in_menu_d   = is_in_menu;
        menu_fall_d = in_menu_q & ~is_in_menu;

        case (state_q)
            S_MENU: begin
                if (!reset_all && menu_fall_q && (|ready)) begin
                    state_d  = S_GAME;
                    winner_d = '0;
                    ticks_d  = '0;
                    presc_d  = '0;
                end
            end
            S_GAME: begin
                // Abort beats finish, and finish beats a tick on the same cycle.
                if (reset_all) begin
                    state_d  = S_MENU;
                    winner_d = '0;
                end else if (|finish) begin
                    state_d  = S_END;
                    winner_d = finish;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (ticks_q != TICKS_MAX) begin
                        ticks_d = ticks_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_END: begin
                if (reset_all) begin
                    state_d  = S_MENU;
                    winner_d = '0;
                end
            end
            default: state_d = S_MENU;
        endcase

        leader_valid_d = (state_d == S_GAME) && lead_found;
        leader_id_d    = leader_valid_d ? lead_id : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_MENU;
            in_menu_q      <= 1'b0;
            menu_fall_q    <= 1'b0;
            winner_q       <= '0;
            leader_valid_q <= 1'b0;
            leader_id_q    <= '0;
            ticks_q        <= '0;
            presc_q        <= '0;
        end else begin
            state_q        <= state_d;
            in_menu_q      <= in_menu_d;
            menu_fall_q    <= menu_fall_d;
            winner_q       <= winner_d;
            leader_valid_q <= leader_valid_d;
            leader_id_q    <= leader_id_d;
            ticks_q        <= ticks_d;
            presc_q        <= presc_d;
        end
    end

    assign current_screen = state_q;
    assign winner_mask    = winner_q;
    assign leader_valid   = leader_valid_q;
    assign leader_id      = leader_id_q;
    assign race_ticks     = ticks_q;

endmodule

// File: tb/tb_race_controller.sv
// Directed scenarios plus a randomized run checked against a behavioural
// model of the race rules (screen, winners, leader, elapsed ticks).
module tb_race_controller;

    localparam int MAX_POS = 16;
    localparam int TICK    = 4;
    localparam int TW      = 2;
    localparam int PW      = $clog2(MAX_POS);
    localparam int TMAX    = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset, reset_all, is_in_menu;
    logic          r_rdy, b_rdy, g_rdy, y_rdy;
    logic [PW-1:0] r_pos, b_pos, g_pos, y_pos;
    logic [1:0]    current_screen;
    logic [3:0]    winner_mask;
    logic          leader_valid;
    logic [1:0]    leader_id;
    logic [TW-1:0] race_ticks;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_scr;
    logic [3:0] m_win;
    int         m_gclk;
    int         m_ticks;
    bit         m_h1, m_h2;
    bit         m_lv;
    int         m_lid;

    always #5 clk = ~clk;

    race_controller #(
        .MAX_POS        (MAX_POS),
        .TICK_CLK_COUNT (TICK),
        .TIME_W         (TW)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .reset_all            (reset_all),
        .is_in_menu           (is_in_menu),
        .red_ready_to_play    (r_rdy),
        .blue_ready_to_play   (b_rdy),
        .green_ready_to_play  (g_rdy),
        .yellow_ready_to_play (y_rdy),
        .red_cur_pos          (r_pos),
        .blue_cur_pos         (b_pos),
        .green_cur_pos        (g_pos),
        .yellow_cur_pos       (y_pos),
        .current_screen       (current_screen),
        .winner_mask          (winner_mask),
        .leader_valid         (leader_valid),
        .leader_id            (leader_id),
        .race_ticks           (race_ticks)
    );

    // Model of one clock edge, using the inputs present just before it.
    task automatic model_step();
        int   p [4];
        bit   rd [4];
        bit   start;
        int   maxp;
        logic [3:0] f;
        rd[0] = r_rdy; rd[1] = b_rdy; rd[2] = g_rdy; rd[3] = y_rdy;
        p[0] = int'(r_pos); p[1] = int'(b_pos); p[2] = int'(g_pos); p[3] = int'(y_pos);
        if (reset) begin
            m_scr = 0; m_win = '0; m_gclk = 0; m_ticks = 0;
            m_h1 = 0; m_h2 = 0; m_lv = 0; m_lid = 0;
            return;
        end
        start = m_h2 && !m_h1;
        f = '0;
        for (int i = 0; i < 4; i++) f[i] = rd[i] && (p[i] == MAX_POS - 1);
        if (m_scr == 0) begin
            if (!reset_all && start && (rd[0] || rd[1] || rd[2] || rd[3])) begin
                m_scr = 1; m_win = '0; m_gclk = 0; m_ticks = 0;
            end
        end else if (m_scr == 1) begin
            if (reset_all) begin
                m_scr = 0; m_win = '0;
            end else if (f != 0) begin
                m_scr = 2; m_win = f;
            end else begin
                m_gclk++;
                m_ticks = (m_gclk / TICK > TMAX) ? TMAX : m_gclk / TICK;
            end
        end else if (reset_all) begin
            m_scr = 0; m_win = '0;
        end
        m_h2 = m_h1;
        m_h1 = is_in_menu;
        maxp = -1;
        for (int i = 0; i < 4; i++) if (rd[i] && p[i] > maxp) maxp = p[i];
        m_lv = (m_scr == 1) && (maxp >= 0);
        m_lid = 0;
        if (m_lv) begin
            for (int i = 3; i >= 0; i--) if (rd[i] && p[i] == maxp) m_lid = i;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic [3:0] m);
        {y_rdy, g_rdy, b_rdy, r_rdy} = m;
    endtask

    // Reset, then walk is_in_menu 1 -> 0 so the race starts.
    task automatic go_game(input logic [3:0] rdy);
        reset = 1'b1; reset_all = 1'b0; tick();
        reset = 1'b0;
        set_ready(rdy);
        is_in_menu = 1'b1; tick(); tick();
        is_in_menu = 1'b0; tick(); tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick();
        reset = 1'b0;
        n_tests++;
        if ({current_screen, winner_mask, leader_valid, leader_id, race_ticks} !== '0) begin
            n_fail++;
            $display("FAIL reset_init: got scr=%b win=%b lv=%b lid=%0d t=%0d, want all 0",
                     current_screen, winner_mask, leader_valid, leader_id, race_ticks);
        end
        r_pos = 4'd7;
        go_game(4'b0001);
        tick(); tick(); tick(); tick(); tick();
        n_tests++;
        if (current_screen !== 2'b01 || race_ticks !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_pre_game: got scr=%b t=%0d, want 01/1", current_screen, race_ticks);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        n_tests++;
        if ({current_screen, winner_mask, leader_valid, leader_id, race_ticks} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_game: got scr=%b win=%b lv=%b lid=%0d t=%0d, want all 0",
                     current_screen, winner_mask, leader_valid, leader_id, race_ticks);
        end
    endtask

    task automatic test_start();
        reset = 1'b1; tick(); reset = 1'b0;
        r_pos = 4'd1; b_pos = 4'd2;
        set_ready(4'b0011);
        is_in_menu = 1'b1; tick(); tick();
        is_in_menu = 1'b0; tick();
        n_tests++;
        if (current_screen !== 2'b00) begin
            n_fail++;
            $display("FAIL start_one_edge: got scr=%b, want 00", current_screen);
        end
        tick();
        n_tests++;
        if (current_screen !== 2'b01) begin
            n_fail++;
            $display("FAIL start_two_edges: got scr=%b, want 01", current_screen);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        set_ready(4'b0000);
        is_in_menu = 1'b1; tick(); tick();
        is_in_menu = 1'b0; tick(); tick(); tick();
        n_tests++;
        if (current_screen !== 2'b00) begin
            n_fail++;
            $display("FAIL start_no_ready: got scr=%b, want 00", current_screen);
        end
    endtask

    task automatic test_leader();
        r_pos = 4'd5; b_pos = 4'd9; g_pos = 4'd9; y_pos = 4'd0;
        go_game(4'b0011);
        tick();
        n_tests++;
        if (leader_valid !== 1'b1 || leader_id !== 2'd1) begin
            n_fail++;
            $display("FAIL leader_blue: got v=%b id=%0d, want 1/1", leader_valid, leader_id);
        end
        r_pos = 4'd9; tick();
        n_tests++;
        if (leader_valid !== 1'b1 || leader_id !== 2'd0) begin
            n_fail++;
            $display("FAIL leader_tie_red: got v=%b id=%0d, want 1/0", leader_valid, leader_id);
        end
        set_ready(4'b1100); g_pos = 4'd3; y_pos = 4'd3; tick();
        n_tests++;
        if (leader_valid !== 1'b1 || leader_id !== 2'd2) begin
            n_fail++;
            $display("FAIL leader_tie_green: got v=%b id=%0d, want 1/2", leader_valid, leader_id);
        end
        set_ready(4'b0000); tick();
        n_tests++;
        if (leader_valid !== 1'b0 || leader_id !== 2'd0 || current_screen !== 2'b01) begin
            n_fail++;
            $display("FAIL leader_none: got v=%b id=%0d scr=%b, want 0/0/01",
                     leader_valid, leader_id, current_screen);
        end
    endtask

    task automatic test_tie_finish();
        r_pos = 4'd15; b_pos = 4'd2; g_pos = 4'd2; y_pos = 4'd2;
        go_game(4'b1010);
        b_pos = 4'd15; y_pos = 4'd15; tick();
        n_tests++;
        if (current_screen !== 2'b10 || winner_mask !== 4'b1010) begin
            n_fail++;
            $display("FAIL tie_finish: got scr=%b win=%b, want 10/1010", current_screen, winner_mask);
        end
        b_pos = 4'd0; set_ready(4'b1111); r_pos = 4'd15;
        for (int i = 0; i < 6; i++) tick();
        n_tests++;
        if (current_screen !== 2'b10 || winner_mask !== 4'b1010 || leader_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL end_hold: got scr=%b win=%b lv=%b, want 10/1010/0",
                     current_screen, winner_mask, leader_valid);
        end
    endtask

    task automatic test_reset_all();
        reset_all = 1'b1; tick(); reset_all = 1'b0;
        n_tests++;
        if (current_screen !== 2'b00 || winner_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_all_end: got scr=%b win=%b, want 00/0000", current_screen, winner_mask);
        end
        r_pos = 4'd3;
        go_game(4'b0001);
        r_pos = 4'd15; reset_all = 1'b1; tick(); reset_all = 1'b0;
        n_tests++;
        if (current_screen !== 2'b00 || winner_mask !== 4'b0000 || leader_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_all_game_finish: got scr=%b win=%b lv=%b, want 00/0000/0",
                     current_screen, winner_mask, leader_valid);
        end
    endtask

    task automatic test_time();
        r_pos = 4'd0;
        go_game(4'b0001);
        tick(); tick(); tick();
        n_tests++;
        if (race_ticks !== 2'd0) begin
            n_fail++;
            $display("FAIL time_before_first: got %0d, want 0", race_ticks);
        end
        tick();
        n_tests++;
        if (race_ticks !== 2'd1) begin
            n_fail++;
            $display("FAIL time_first_tick: got %0d, want 1", race_ticks);
        end
        for (int i = 0; i < 16; i++) tick();
        n_tests++;
        if (race_ticks !== 2'd3) begin
            n_fail++;
            $display("FAIL time_saturate: got %0d, want 3", race_ticks);
        end
        go_game(4'b0001);
        for (int i = 0; i < 7; i++) tick();
        r_pos = 4'd15; tick();
        n_tests++;
        if (current_screen !== 2'b10 || race_ticks !== 2'd1) begin
            n_fail++;
            $display("FAIL time_finish_drops_tick: got scr=%b t=%0d, want 10/1", current_screen, race_ticks);
        end
        for (int i = 0; i < 12; i++) tick();
        n_tests++;
        if (race_ticks !== 2'd1) begin
            n_fail++;
            $display("FAIL time_frozen_end: got %0d, want 1", race_ticks);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            reset_all = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) is_in_menu = ~is_in_menu;
            if ($urandom_range(0, 15) == 0) set_ready(4'($urandom_range(0, 15)));
            r_pos = ($urandom_range(0, 40) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            b_pos = ($urandom_range(0, 40) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            g_pos = ($urandom_range(0, 40) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            y_pos = ($urandom_range(0, 40) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            tick();
            n_tests++;
            if (current_screen !== 2'(m_scr) || winner_mask !== m_win || race_ticks !== TW'(m_ticks)) begin
                n_fail++;
                $display("FAIL rand_state c=%0d: got scr=%b win=%b t=%0d, want scr=%0d win=%b t=%0d",
                         c, current_screen, winner_mask, race_ticks, m_scr, m_win, m_ticks);
            end
            n_tests++;
            if (leader_valid !== m_lv || leader_id !== 2'(m_lid)) begin
                n_fail++;
                $display("FAIL rand_leader c=%0d: got v=%b id=%0d, want v=%b id=%0d",
                         c, leader_valid, leader_id, m_lv, m_lid);
            end
        end
        reset = 1'b0; reset_all = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reset_all = 1'b0; is_in_menu = 1'b0;
        set_ready(4'b0000);
        r_pos = '0; b_pos = '0; g_pos = '0; y_pos = '0;
        m_scr = 0; m_win = '0; m_gclk = 0; m_ticks = 0;
        m_h1 = 0; m_h2 = 0; m_lv = 0; m_lid = 0;
        #1;
        test_reset();
        test_start();
        test_leader();
        test_tie_finish();
        test_reset_all();
        test_time();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
